// File: rtl/demux_pkg.sv
// Shared types and helpers for the demux_stream streaming demultiplexer.
package demux_pkg;

    typedef enum logic [0:0] {
        DEMUX_IDLE = 1'b0,
        DEMUX_PKT  = 1'b1
    } demux_state_e;

    function automatic logic demux_sel_valid(input logic [31:0] sel, input logic [31:0] n_ch);
        return sel < n_ch;
    endfunction

endpackage

// File: rtl/demux_dec.sv
// Binary-to-one-hot decoder with enable; out-of-range selects give all zeros.
// Purely combinational, no latency, no flow control.
module demux_dec
    import demux_pkg::*;
#(
    parameter int N_OUT = 32,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  logic             en_i,
    input  logic [SEL_W-1:0] sel_i,
    output logic [N_OUT-1:0] onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i && demux_sel_valid(32'(sel_i), 32'(N_OUT))) begin
            for (int k = 0; k < N_OUT; k++) begin
                onehot_o[k] = (sel_i == SEL_W'(k));
            end
        end
    end

endmodule

// File: rtl/demux_stream.sv
// 1-to-N_CH packet-locked stream demux; one output register stage, latency 1 beat.
// Backpressure: s_ready_o follows the selected channel's ready when the stage is full; en_i low stalls input only.
// Optional DEMUX_STREAM_ERR_EN adds sticky err_o for beats dropped on an invalid channel.
module demux_stream
    import demux_pkg::*;
#(
    parameter int N_CH   = 32,
    parameter int DATA_W = 8,
    parameter int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     en_i,
    input  logic [SEL_W-1:0]         sel_i,
    input  logic                     s_valid_i,
    output logic                     s_ready_o,
    input  logic [DATA_W-1:0]        s_data_i,
    input  logic                     s_last_i,
    output logic [N_CH-1:0]          m_valid_o,
    input  logic [N_CH-1:0]          m_ready_i,
    output logic [N_CH*DATA_W-1:0]   m_data_o,
    output logic [N_CH-1:0]          m_last_o
`ifdef DEMUX_STREAM_ERR_EN
    ,
    output logic                     err_o
`endif
);

    demux_state_e      state_q, state_d;
    logic [SEL_W-1:0]  lock_q, lock_d;
    logic              stg_vld_q, stg_vld_d;
    logic [DATA_W-1:0] stg_dat_q, stg_dat_d;
    logic              stg_last_q, stg_last_d;
    logic [SEL_W-1:0]  stg_ch_q, stg_ch_d;

    logic [N_CH-1:0]   stg_hot;
    logic              drain;
    logic              accept;
    logic [SEL_W-1:0]  beat_ch;
    logic              beat_ok;

    demux_dec #(
        .N_OUT (N_CH),
        .SEL_W (SEL_W)
    ) u_dec (
        .en_i     (stg_vld_q),
        .sel_i    (stg_ch_q),
        .onehot_o (stg_hot)
    );

    // The stage only ever holds beats for valid channels, so the one-hot picks its consumer's ready.
    assign drain     = |(stg_hot & m_ready_i);
    assign s_ready_o = rst_ni && en_i && (!stg_vld_q || drain);
    assign accept    = s_valid_i && s_ready_o;
    assign beat_ch   = (state_q == DEMUX_PKT) ? lock_q : sel_i;
    assign beat_ok   = demux_sel_valid(32'(beat_ch), 32'(N_CH));

    always_comb begin
        state_d    = state_q;
        lock_d     = lock_q;
        stg_vld_d  = stg_vld_q;
        stg_dat_d  = stg_dat_q;
        stg_last_d = stg_last_q;
        stg_ch_d   = stg_ch_q;

        if (drain) begin
            stg_vld_d = 1'b0;
        end

        if (accept) begin
            // Invalid-channel beats are consumed but never become visible.
            stg_vld_d  = beat_ok;
            stg_dat_d  = s_data_i;
            stg_last_d = s_last_i;
            stg_ch_d   = beat_ch;

            case (state_q)
                DEMUX_IDLE: begin
                    if (!s_last_i) begin
                        lock_d  = sel_i;
                        state_d = DEMUX_PKT;
                    end
                end
                DEMUX_PKT: begin
                    if (s_last_i) begin
                        state_d = DEMUX_IDLE;
                    end
                end
                default: state_d = DEMUX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= DEMUX_IDLE;
            lock_q     <= '0;
            stg_vld_q  <= 1'b0;
            stg_dat_q  <= '0;
            stg_last_q <= 1'b0;
            stg_ch_q   <= '0;
        end else begin
            state_q    <= state_d;
            lock_q     <= lock_d;
            stg_vld_q  <= stg_vld_d;
            stg_dat_q  <= stg_dat_d;
            stg_last_q <= stg_last_d;
            stg_ch_q   <= stg_ch_d;
        end
    end

    always_comb begin
        m_valid_o = stg_hot;
        m_last_o  = stg_hot & {N_CH{stg_last_q}};
        m_data_o  = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (stg_hot[k]) begin
                m_data_o[k*DATA_W +: DATA_W] = stg_dat_q;
            end
        end
    end

`ifdef DEMUX_STREAM_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (accept && !beat_ok) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_o = err_q;
`endif

endmodule

// File: tb/tb_demux_stream.sv
// Randomized bench for demux_stream (N_CH=20 so out-of-range selects occur) against a beat-queue model.
module tb_demux_stream;

    localparam int N_CH   = 20;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 5;
    localparam int N_CYC  = 4000;

    typedef struct {
        int         ch;
        logic [7:0] dat;
        logic       last;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   en = 1'b0;
    logic [SEL_W-1:0]       sel = '0;
    logic                   s_valid = 1'b0;
    logic                   s_ready;
    logic [DATA_W-1:0]      s_data = '0;
    logic                   s_last = 1'b0;
    logic [N_CH-1:0]        m_valid;
    logic [N_CH-1:0]        m_ready = '0;
    logic [N_CH*DATA_W-1:0] m_data;
    logic [N_CH-1:0]        m_last;
`ifdef DEMUX_STREAM_ERR_EN
    logic                   err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    demux_stream #(
        .N_CH   (N_CH),
        .DATA_W (DATA_W)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .en_i      (en),
        .sel_i     (sel),
        .s_valid_i (s_valid),
        .s_ready_o (s_ready),
        .s_data_i  (s_data),
        .s_last_i  (s_last),
        .m_valid_o (m_valid),
        .m_ready_i (m_ready),
        .m_data_o  (m_data),
        .m_last_o  (m_last)
`ifdef DEMUX_STREAM_ERR_EN
        ,
        .err_o     (err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Producer-side packet bookkeeping: the routing channel is known from the packet itself.
    int dir_sel [3] = '{5, 3, 25};
    int dir_len [3] = '{1, 3, 2};
    int pkt_idx  = -1;
    int pkt_sel  = 0;
    int pkt_len  = 1;
    int beat_idx = 0;
    logic beat_live = 1'b0;

    task automatic new_pkt();
        pkt_idx++;
        beat_idx = 0;
        if (pkt_idx < 3) begin
            pkt_sel = dir_sel[pkt_idx];
            pkt_len = dir_len[pkt_idx];
        end else begin
            pkt_sel = $urandom_range(0, 31);
            pkt_len = $urandom_range(1, 4);
        end
    endtask

    initial begin
        beat_t                  q[$];
        beat_t                  b;
        logic [N_CH-1:0]        exp_vld;
        logic [N_CH-1:0]        exp_last;
        logic [N_CH*DATA_W-1:0] exp_dat;
        logic                   exp_rdy;
        logic                   err_exp;
        int                     delivered;
        int                     dropped;
        int                     n_rst;

        err_exp   = 1'b0;
        delivered = 0;
        dropped   = 0;
        n_rst     = 0;
        new_pkt();

        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);

            exp_vld  = '0;
            exp_last = '0;
            exp_dat  = '0;
            if (q.size() > 0) begin
                exp_vld[q[0].ch]                 = 1'b1;
                exp_last[q[0].ch]                = q[0].last;
                exp_dat[q[0].ch*DATA_W +: DATA_W] = q[0].dat;
            end
            exp_rdy = rst_n && en && (q.size() == 0 || m_ready[q[0].ch]);

            chk("m_valid", 256'(m_valid), 256'(exp_vld));
            chk("m_data",  256'(m_data),  256'(exp_dat));
            chk("m_last",  256'(m_last),  256'(exp_last));
            chk("s_ready", 256'(s_ready), 256'(exp_rdy));
`ifdef DEMUX_STREAM_ERR_EN
            chk("err", 256'(err), 256'(err_exp));
`endif

            if (q.size() > 0 && m_ready[q[0].ch]) begin
                void'(q.pop_front());
                delivered++;
            end

            if (!rst_n) begin
                q.delete();
                err_exp   = 1'b0;
                beat_live = 1'b0;
                if (beat_idx > 0) new_pkt();
            end else if (s_valid && s_ready) begin
                if (pkt_sel < N_CH) begin
                    b.ch   = pkt_sel;
                    b.dat  = s_data;
                    b.last = s_last;
                    q.push_back(b);
                end else begin
                    err_exp = 1'b1;
                    dropped++;
                end
                beat_live = 1'b0;
                if (s_last) new_pkt();
                else beat_idx++;
            end

            @(posedge clk);
            #1;
            rst_n = (cyc >= 2);
            if (n_rst < 2 && cyc > 1500 * (n_rst + 1) && beat_idx > 0) begin
                rst_n = 1'b0;
                n_rst++;
            end

            if (cyc < 40) begin
                en      = 1'b1;
                m_ready = '1;
            end else begin
                en = ($urandom_range(0, 9) != 0);
                for (int k = 0; k < N_CH; k++) m_ready[k] = ($urandom_range(0, 9) < 6);
            end

            if (!beat_live) begin
                if (cyc < 40 || $urandom_range(0, 3) != 0) begin
                    s_valid = 1'b1;
                    s_last  = (beat_idx == pkt_len - 1);
                    if (beat_idx == 0) sel = SEL_W'(pkt_sel);
                    else if (pkt_idx == 1) sel = SEL_W'(7);
                    else sel = SEL_W'($urandom_range(0, 31));
                    if (pkt_idx == 0) s_data = 8'hA5;
                    else s_data = 8'($urandom_range(0, 255));
                    beat_live = 1'b1;
                end else begin
                    s_valid = 1'b0;
                end
            end
        end

        chk("delivered_enough", 256'(delivered > 300), 256'(1));
        chk("dropped_seen",     256'(dropped > 10),    256'(1));
        chk("resets_done",      256'(n_rst),           256'(2));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
